// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-Lite slave FSM that sequences APB SETUP/ACCESS phases for the AHB-to-APB bridge.
// Latency: 4 cycles address->HREADYOUT for a zero-wait slave; backpressure via HREADYOUT low while APB is busy.
module ahb_apb_bridge_ctrl #(
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        psel_en,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

    localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [8:0]      SLOTS    = 9'(NUM_SLAVES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          valid;
    logic          mapped;
    logic          unused_htrans;

    assign valid         = HSEL & HREADY & HTRANS[1];
    assign mapped        = ({1'b0, HADDR[23:16]} < SLOTS);
    assign unused_htrans = HTRANS[0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PENABLE   <= 1'b0;
            psel_en   <= 1'b0;
        end else begin
            case (state)
                // ERR2 is the second error cycle but already accepts a new address phase.
                IDLE, ERR2: begin
                    if (valid && mapped) begin
                        state     <= LATCH;
                        PADDR     <= HADDR;
                        PWRITE    <= HWRITE;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b0;
                    end else if (valid) begin
                        state     <= ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
                LATCH: begin
                    if (PWRITE) PWDATA <= HWDATA;
                    psel_en <= 1'b1;
                    state   <= SETUP;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_en <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            state <= ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            HREADYOUT <= 1'b1;
                            if (!PWRITE) HRDATA <= PRDATA;
                        end
                    end else begin
                        if (cnt != '1) cnt <= cnt + CW'(1);
                        // Abort after TIMEOUT ACCESS cycles without PREADY.
                        if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                            psel_en <= 1'b0;
                            PENABLE <= 1'b0;
                            state   <= ERR1;
                            HRESP   <= 1'b1;
                        end
                    end
                end
                ERR1: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                    state     <= ERR2;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Randomised scoreboard bench for ahb_apb_bridge_ctrl with a behavioural APB slave and transfer model.
module tb_ahb_apb_bridge_ctrl;

    localparam int NS = 2;
    localparam int TO = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        psel_en;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    ahb_apb_bridge_ctrl #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .psel_en(psel_en), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    typedef struct {
        bit          resp;
        logic [31:0] hrdata;
        int          pen;
        int          setup;
        logic [31:0] paddr;
        bit          pwrite;
        logic [31:0] pwdata;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] m_hrdata = '0;
    logic [31:0] m_pwdata = '0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // APB slave: PREADY after cur_wait low ACCESS cycles; junk on the bus otherwise.
    int          cur_wait = 0;
    bit          cur_err = 1'b0;
    logic [31:0] cur_rdata = '0;
    int          slv_cnt = 0;

    always @(negedge HCLK) begin
        if (psel_en && PENABLE) begin
            PREADY  = (slv_cnt >= cur_wait);
            slv_cnt++;
            PRDATA  = PREADY ? cur_rdata : $urandom;
            PSLVERR = PREADY ? cur_err : 1'($urandom_range(0, 1));
        end else begin
            slv_cnt = 0;
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: tracks APB activity and checks each completed AHB response against the scoreboard.
    logic        mon_en = 1'b0;
    logic        prev_ro = 1'b1;
    logic        prev_resp = 1'b0;
    int          pen_n = 0;
    int          setup_n = 0;
    bit          seen = 1'b0;
    bit          unstable = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_w = 1'b0;

    always @(negedge HCLK) begin
        if (!mon_en) begin
            pen_n = 0; setup_n = 0; seen = 1'b0; unstable = 1'b0;
        end else begin
            if (psel_en) begin
                if (PENABLE) pen_n++; else setup_n++;
                if (!seen) begin
                    seen = 1'b1; cap_addr = PADDR; cap_w = PWRITE; cap_wdata = PWDATA;
                end else if (PADDR !== cap_addr || PWRITE !== cap_w || PWDATA !== cap_wdata) begin
                    unstable = 1'b1;
                end
            end
            if (HREADYOUT && !prev_ro) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_completion: got HRESP=%b with empty scoreboard", HRESP);
                end else begin
                    mon_e = sb.pop_front();
                    chk("hresp", 32'(HRESP), 32'(mon_e.resp));
                    chk("err1_hresp", 32'(prev_resp), 32'(mon_e.resp));
                    chk("hrdata", HRDATA, mon_e.hrdata);
                    chk("penable_cycles", pen_n, mon_e.pen);
                    chk("setup_cycles", setup_n, mon_e.setup);
                    chk("latency", cyc - mon_e.t0, mon_e.lat);
                    if (mon_e.setup != 0) begin
                        chk("paddr", cap_addr, mon_e.paddr);
                        chk("pwrite", 32'(cap_w), 32'(mon_e.pwrite));
                        chk("pwdata", cap_wdata, mon_e.pwdata);
                        chk("apb_stable", 32'(unstable), 32'd0);
                    end
                end
                pen_n = 0; setup_n = 0; seen = 1'b0; unstable = 1'b0;
            end
        end
        prev_ro   = HREADYOUT;
        prev_resp = HRESP;
    end

    // Reference model: outcome of one transfer from the address, direction and slave behaviour.
    task automatic issue(input logic [31:0] addr, input bit w, input logic [31:0] wdata,
                         input int wt, input bit er, input logic [31:0] rdata);
        exp_t e;
        int   k;
        k = 0;
        while (HREADYOUT !== 1'b1 && k < 64) begin
            @(negedge HCLK);
            k++;
        end
        if (k == 64) begin
            n_chk++; n_fail++;
            $display("FAIL hreadyout_wait: got %b expected 1 within 64 cycles", HREADYOUT);
        end
        cur_wait = wt; cur_err = er; cur_rdata = rdata;
        e.paddr = addr; e.pwrite = w;
        if (int'(addr[23:16]) >= NS) begin
            e.resp = 1'b1; e.pen = 0; e.setup = 0; e.lat = 2;
        end else begin
            e.setup = 1;
            if (w) m_pwdata = wdata;
            if (wt >= TO) begin
                e.resp = 1'b1; e.pen = TO; e.lat = TO + 4;
            end else if (er) begin
                e.resp = 1'b1; e.pen = wt + 1; e.lat = wt + 5;
            end else begin
                e.resp = 1'b0; e.pen = wt + 1; e.lat = wt + 4;
                if (!w) m_hrdata = rdata;
            end
        end
        e.pwdata = m_pwdata;
        e.hrdata = m_hrdata;
        e.t0 = cyc;
        sb.push_back(e);
        HSEL = 1'b1; HADDR = addr; HWRITE = w;
        HTRANS = {1'b1, 1'($urandom_range(0, 1))};
        @(negedge HCLK);
        HWDATA = w ? wdata : $urandom;
        HSEL   = 1'($urandom_range(0, 1));
        HTRANS = {1'b0, 1'($urandom_range(0, 1))};
        HADDR  = $urandom;
        HWRITE = 1'($urandom_range(0, 1));
    endtask

    task automatic gap(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 2);
            HADDR = $urandom;
            if (r == 0) begin HSEL = 1'b0; HTRANS = 2'b10; end
            else begin HSEL = 1'b1; HTRANS = {1'b0, r[0]}; end
            @(negedge HCLK);
        end
    endtask

    task automatic drain;
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge HCLK);
            k++;
        end
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          k;
        repeat (3) @(negedge HCLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_psel_en", 32'(psel_en), 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        mon_en = 1'b1;
        @(negedge HCLK);

        issue(32'h0001_0004, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        issue(32'h0000_0010, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h0);
        issue(32'h0001_0008, 1'b0, 32'h0, 0, 1'b1, 32'h5555_AAAA);
        issue(32'h0005_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        issue(32'h0000_0020, 1'b0, 32'h0, 10, 1'b0, 32'h0);
        issue(32'h0001_0000, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001);

        for (int t = 0; t < 200; t++) begin
            a = $urandom;
            a[23:16] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
            issue(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5),
                  ($urandom_range(0, 4) == 0), $urandom);
            gap($urandom_range(0, 2));
        end
        drain();

        issue(32'h0000_0040, 1'b0, 32'h0, 10, 1'b0, 32'h0);
        k = 0;
        while (PENABLE !== 1'b1 && k < 20) begin
            @(negedge HCLK);
            k++;
        end
        mon_en = 1'b0;
        chk("reach_access", 32'(PENABLE), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_psel_en", 32'(psel_en), 32'd0);
        chk("arst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("arst_hrdata", HRDATA, 32'd0);
        chk("arst_hresp", 32'(HRESP), 32'd0);
        sb.delete();
        m_hrdata = '0;
        m_pwdata = '0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1 mon_en = 1'b1;
        @(negedge HCLK);
        issue(32'h0001_0100, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
        issue(32'h0000_0104, 1'b1, 32'hCAFE_0123, 1, 1'b0, 32'h0);
        issue(32'h0000_0108, 1'b0, 32'h0, 2, 1'b0, 32'h7777_1234);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_ctrl.md
Name: ahb_apb_bridge_ctrl

Overview:
- AHB-Lite slave state machine that sequences the APB bus for the AHB-to-APB bridge.
- Latches AHB address and write data, then drives PADDR, PWDATA, PWRITE, PENABLE and the decoder's psel_en through APB SETUP/ACCESS phases.
- Waits for PREADY, returns the read data supplied by the APB decoder's read mux, and converts PSLVERR, unmapped slots and timeouts into AHB two-cycle ERROR responses.

Parameters:
- NUM_SLAVES, 2: number of APB slots; slot index is HADDR[23:16].
- TIMEOUT, 256: max ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  bridge selected.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; only NONSEQ (10) and SEQ (11) are valid.
- HWRITE  in  1  write transfer.
- HREADY  in  1  AHB bus ready.
- HWDATA  in  32  write data.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  1 = ERROR.
- PADDR  out  32  APB address, also feeds the decoder.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- psel_en  out  1  select enable to the decoder.
- PRDATA  in  32  muxed slave read data from the decoder.
- PREADY  in  1  selected slave ready.
- PSLVERR  in  1  selected slave error.

Behaviour:
- Reset: all outputs registered. On HRESETn low, immediately and regardless of state: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PWDATA=0, PWRITE=0, PENABLE=0, psel_en=0, timeout counter 0. An APB transfer in progress is abandoned.
- Valid transfer: HSEL & HREADY & HTRANS[1]. BUSY and IDLE HTRANS are ignored.
- States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0, psel_en=0, PENABLE=0.
  - On a valid transfer, if HADDR[23:16] >= NUM_SLAVES: go to ERR1; PADDR and APB outputs are not updated.
  - Otherwise on a valid transfer: PADDR <= HADDR, PWRITE <= HWRITE, go to LATCH.
- LATCH (AHB data phase): HREADYOUT=0. PWDATA <= HWDATA for writes; PWDATA unchanged for reads. Go to SETUP.
- SETUP: psel_en=1, PENABLE=0, HREADYOUT=0. Go to ACCESS and clear the counter.
- ACCESS: psel_en=1, PENABLE=1, HREADYOUT=0.
  - PREADY & !PSLVERR: reads capture HRDATA <= PRDATA; go to IDLE with psel_en=0, PENABLE=0.
  - PREADY & PSLVERR: go to ERR1 with psel_en=0, PENABLE=0; HRDATA is not updated.
  - PREADY low: counter increments. When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with PREADY still low, drop psel_en and PENABLE and go to ERR1.
- ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. A valid transfer seen here is handled exactly as in IDLE; otherwise go to IDLE.
- Latency, zero-wait slave: 4 cycles from address phase to HREADYOUT high (address, LATCH, SETUP, ACCESS). Data returns in the following IDLE cycle.
- Back-to-back: a transfer presented in the completing IDLE cycle is accepted with no bubble.
- Held values:
  - PADDR and PWRITE hold between transfers.
  - HRDATA holds until the next successful read.
  - Address, data and control never change during SETUP or ACCESS.
- Timeout counter saturates and is cleared on SETUP entry.
- Decoder contract: psel_en is high only in SETUP and ACCESS, so the decoder's one-hot select is active for exactly those cycles.

Test Plan:
- Read, zero-wait: HADDR=0x0001_0004, HTRANS=10, HWRITE=0, PREADY=1, PRDATA=0xDEAD_BEEF -> SETUP on cycle 2 with psel_en=1, PENABLE=0; ACCESS on cycle 3; HREADYOUT=1 and HRDATA=0xDEAD_BEEF on cycle 4; HRESP=0.
- Write with 3 wait states: HADDR=0x0000_0010, HWDATA=0x1234_5678, PREADY low for 3 ACCESS cycles -> PWDATA=0x1234_5678 and PWRITE=1 stable from SETUP; PENABLE high 4 cycles; HREADYOUT high on the cycle after PREADY.
- Slave error: read with PREADY=1, PSLVERR=1 -> psel_en drops; HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then IDLE; HRDATA keeps its old value.
- Unmapped slot: NUM_SLAVES=2, HADDR=0x0005_0000 -> psel_en never asserts; ERR1 then ERR2 immediately after the address phase.
- Timeout: TIMEOUT=4, PREADY held 0 -> PENABLE high exactly 4 cycles, then two-cycle ERROR; a subsequent zero-wait read completes normally.
- Reset mid-ACCESS: HRESETn pulsed low during ACCESS -> PENABLE=0, psel_en=0, HREADYOUT=1, HRDATA=0 with no clock edge; a new transfer after release completes in 4 cycles.
